spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_ctrl_pkg.sv | 35 +++
 rtl/spi_clk_gen.sv | 67 ++++++
 rtl/spi_controller.sv | 148 ++++++++++++++
 tb/tb_spi_controller.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI register-access controller.
//   - FSM state encoding
//   - frame geometry: 16 bits, rw at bit 15, addr at bits 14:8, data at bits 7:0
//   - rw encoding (1 = write)
//   - build_frame(): assembles the outgoing frame. Read frames carry a zero data byte.
package spi_ctrl_pkg;

   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned RW_BIT     = 15;
   localparam int unsigned ADDR_MSB   = 14;
   localparam int unsigned ADDR_LSB   = 8;
   localparam int unsigned DATA_BITS  = 8;
   localparam logic        RW_WRITE   = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StShift,
      StHold
   } state_e;

   function automatic logic [FRAME_BITS-1:0] build_frame(input logic           rw,
                                                          input logic [6:0]     addr,
                                                          input logic [7:0]     wdata);
      logic [FRAME_BITS-1:0] frame;
      frame                    = '0;
      frame[RW_BIT]            = rw;
      frame[ADDR_MSB:ADDR_LSB] = addr;
      if (rw == RW_WRITE) begin
         frame[DATA_BITS-1:0] = wdata;
      end
      return frame;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK timing generator for spi_controller.
// Produces a tick every CLK_DIV clk cycles while 'run' is high, toggles sclk on each tick
// while 'shift_en' is high, and counts falling edges to flag the last one of the frame.
// Ports:
//   clk, rst   - system clock, asynchronous active-high reset
//   run        - enable the half-period counter (held in reset when low)
//   shift_en   - enable sclk toggling and the edge count (sclk forced low when low)
//   tick       - one-cycle strobe at the end of each CLK_DIV-cycle interval
//   sclk       - SPI clock, idles low
//   rise, fall - strobes in the cycle whose closing clk edge raises / lowers sclk
//   last_fall  - fall strobe of the final (16th) falling edge
module spi_clk_gen
   import spi_ctrl_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic shift_en,
   output logic tick,
   output logic sclk,
   output logic rise,
   output logic fall,
   output logic last_fall
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q;
   logic       sclk_q;
   logic [4:0] edge_cnt_q;

   assign tick      = run && (cnt_q == DIV_LAST);
   assign rise      = shift_en && tick && !sclk_q;
   assign fall      = shift_en && tick && sclk_q;
   assign last_fall = fall && (edge_cnt_q == 5'(FRAME_BITS - 1));
   assign sclk      = sclk_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         sclk_q     <= 1'b0;
         edge_cnt_q <= '0;
      end else begin
         // Counter restarts on every tick so each FSM phase begins on a fresh interval.
         if (!run || tick) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 8'd1;
         end

         if (!shift_en) begin
            sclk_q <= 1'b0;
         end else if (tick) begin
            sclk_q <= ~sclk_q;
         end

         if (!shift_en) begin
            edge_cnt_q <= '0;
         end else if (fall) begin
            edge_cnt_q <= edge_cnt_q + 5'd1;
         end
      end
   end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 register-access controller. One start request issues a 16-bit frame
// {rw, addr[6:0], data[7:0]} MSB first, framed by ncs, with CLK_DIV clk cycles per
// sclk half-period. Phases: IDLE -> SETUP (CLK_DIV) -> SHIFT (32 half-periods)
// -> HOLD (CLK_DIV) -> IDLE with a one-cycle done pulse.
// Build option: define SPI_CTRL_READ_EN to capture cipo on read frames into rdata;
// without it cipo is ignored and rdata is constant zero.
// Ports:
//   clk, rst            - system clock, asynchronous active-high reset
//   start               - frame request, accepted only in IDLE and not during done
//   rw, addr, wdata     - frame fields, latched when start is accepted
//   cipo                - serial data from the peripheral, sampled on sclk rising edges
//   sclk, copi, ncs     - SPI bus (sclk idles low, ncs active-low)
//   busy                - frame in progress
//   done                - one-cycle pulse at frame end
//   rdata               - last read byte (sclk rising edges 9..16)
module spi_controller
   import spi_ctrl_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   input  logic       cipo,
   output logic       sclk,
   output logic       copi,
   output logic       ncs,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata
);

   state_e                state_q, state_d;
   logic [FRAME_BITS-1:0] tx_q, tx_d;
   logic                  rw_q, rw_d;
   logic                  done_q, done_d;

   logic run, shift_en;
   logic tick, rise, fall, last_fall;
   logic sclk_int;

   assign run      = (state_q != StIdle);
   assign shift_en = (state_q == StShift);

   spi_clk_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_clk_gen (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .shift_en (shift_en),
      .tick     (tick),
      .sclk     (sclk_int),
      .rise     (rise),
      .fall     (fall),
      .last_fall(last_fall)
   );

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rw_d    = rw_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            // A start coinciding with done is dropped so frames are always separated.
            if (start && !done_q) begin
               state_d = StSetup;
               tx_d    = build_frame(rw, addr, wdata);
               rw_d    = rw;
            end
         end
         StSetup: begin
            if (tick) begin
               state_d = StShift;
            end
         end
         StShift: begin
            // copi advances only on sclk falling edges (mode 0).
            if (fall) begin
               tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
            end
            if (last_fall) begin
               state_d = StHold;
            end
         end
         StHold: begin
            if (tick) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         tx_q    <= '0;
         rw_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rw_q    <= rw_d;
         done_q  <= done_d;
      end
   end

   assign ncs  = (state_q == StIdle);
   assign busy = (state_q != StIdle);
   assign copi = (state_q != StIdle) && tx_q[FRAME_BITS-1];
   assign sclk = sclk_int;
   assign done = done_q;

`ifdef SPI_CTRL_READ_EN
   logic [DATA_BITS-1:0] rx_q;
   logic [DATA_BITS-1:0] rdata_q;

   // rx_q keeps the last eight sampled bits, i.e. rising edges 9..16 by the end of SHIFT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_q    <= '0;
         rdata_q <= '0;
      end else begin
         if (rise) begin
            rx_q <= {rx_q[DATA_BITS-2:0], cipo};
         end
         if ((state_q == StHold) && tick && (rw_q != RW_WRITE)) begin
            rdata_q <= rx_q;
         end
      end
   end

   assign rdata = rdata_q;
`else
   logic unused_read;
   assign unused_read = ^{cipo, rise, rw_q};
   assign rdata       = '0;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: CLK_DIV=4 instance for frame, read, abort and
// start-filtering scenarios; CLK_DIV=1 instance for back-to-back frames.
module tb_spi_controller;

   localparam int unsigned DIV       = 4;
   localparam int          FRAME_CYC = 34 * DIV + 1;

`ifdef SPI_CTRL_READ_EN
   localparam logic READ_EN = 1'b1;
`else
   localparam logic READ_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start, rw, cipo;
   logic [6:0] addr;
   logic [7:0] wdata;
   logic       sclk, copi, ncs, busy, done;
   logic [7:0] rdata;

   logic       start1, rw1, cipo1;
   logic [6:0] addr1;
   logic [7:0] wdata1;
   logic       sclk1, copi1, ncs1, busy1, done1;
   logic [7:0] rdata1;

   int   checks   = 0;
   int   failures = 0;
   logic exp_q[$];

   always #5 clk = ~clk;

   spi_controller #(.CLK_DIV(DIV)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .rw   (rw),
      .addr (addr),
      .wdata(wdata),
      .cipo (cipo),
      .sclk (sclk),
      .copi (copi),
      .ncs  (ncs),
      .busy (busy),
      .done (done),
      .rdata(rdata)
   );

   spi_controller #(.CLK_DIV(1)) dut1 (
      .clk  (clk),
      .rst  (rst),
      .start(start1),
      .rw   (rw1),
      .addr (addr1),
      .wdata(wdata1),
      .cipo (cipo1),
      .sclk (sclk1),
      .copi (copi1),
      .ncs  (ncs1),
      .busy (busy1),
      .done (done1),
      .rdata(rdata1)
   );

   // Drives one frame on dut starting in cycle 0 (caller is at a negedge). Observes every
   // cycle at the negedge; scoreboard bits are popped at each sclk rise. The peripheral
   // model presents fcipo on rising edges 9..16.
   task automatic run_frame(input logic frw, input logic [6:0] faddr, input logic [7:0] fwdata,
                            input logic [7:0] fcipo, input int spam, input int abort_at,
                            input int run_len, output int done_cyc, output int done_cnt,
                            output int ncs_low, output int rises, output logic [7:0] rdata_done,
                            output logic [7:0] rdata_pre, output int busy_after);
      logic [15:0] frame;
      logic        prev_sclk;
      logic        exp_bit;
      int          k;
      frame = {frw, faddr, (frw ? fwdata : 8'h00)};
      exp_q.delete();
      for (int i = 15; i >= 0; i--) exp_q.push_back(frame[i]);
      done_cyc   = -1;
      done_cnt   = 0;
      ncs_low    = 0;
      rises      = 0;
      busy_after = 0;
      rdata_done = 8'hxx;
      rdata_pre  = rdata;
      prev_sclk  = 1'b0;
      rw    = frw;
      addr  = faddr;
      wdata = fwdata;
      cipo  = 1'b0;
      start = 1'b1;
      for (int cyc = 1; cyc <= run_len; cyc++) begin
         @(negedge clk);
         start = (spam != 0) && (cyc == 10 || cyc == 100);
         // Scramble inputs: the frame must come from the latched copy.
         rw    = ~frw;
         addr  = ~faddr;
         wdata = ~fwdata;
         if (cyc == 1) begin
            checks++;
            if (ncs !== 1'b0 || busy !== 1'b1 || copi !== frame[15]) begin
               failures++;
               $display("FAIL setup_cycle1: ncs=%b busy=%b copi=%b required ncs=0 busy=1 copi=%b",
                        ncs, busy, copi, frame[15]);
            end
         end
         if (cyc == abort_at) begin
            rst = 1'b1;
            #1;
            checks++;
            if ({ncs, sclk, busy, copi, done} !== 5'b10000) begin
               failures++;
               $display("FAIL async_abort: ncs,sclk,busy,copi,done=%b required 10000",
                        {ncs, sclk, busy, copi, done});
            end
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (sclk === 1'b1 && prev_sclk === 1'b0) begin
            rises++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL copi_extra_rise: rise %0d at cycle %0d, required no rise", rises, cyc);
            end else begin
               exp_bit = exp_q.pop_front();
               if (copi !== exp_bit) begin
                  failures++;
                  $display("FAIL copi_bit: rise %0d got %b required %b", rises, copi, exp_bit);
               end
            end
         end
         prev_sclk = sclk;
         if (ncs === 1'b0) ncs_low++;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc   = cyc;
               rdata_done = rdata;
               checks++;
               if (ncs !== 1'b1 || busy !== 1'b0) begin
                  failures++;
                  $display("FAIL done_cycle_idle: ncs=%b busy=%b required ncs=1 busy=0", ncs, busy);
               end
            end
         end else if (done_cyc >= 0 && busy === 1'b1) begin
            busy_after++;
         end else if (done_cyc < 0) begin
            rdata_pre = rdata;
         end
         k    = rises + 1;
         cipo = (k >= 9 && k <= 16) ? fcipo[16-k] : 1'b0;
      end
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      start  = 1'b0;
      rw     = 1'b0;
      addr   = '0;
      wdata  = '0;
      cipo   = 1'b0;
      start1 = 1'b0;
      rw1    = 1'b0;
      addr1  = '0;
      wdata1 = '0;
      cipo1  = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (ncs !== 1'b1) begin failures++; $display("FAIL reset_ncs: got %b required 1", ncs); end
      checks++;
      if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk: got %b required 0", sclk); end
      checks++;
      if (copi !== 1'b0) begin failures++; $display("FAIL reset_copi: got %b required 0", copi); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", done); end
      checks++;
      if (rdata !== 8'h00) begin
         failures++;
         $display("FAIL reset_rdata: got %h required 00", rdata);
      end
      checks++;
      if ({ncs1, sclk1, busy1} !== 3'b100) begin
         failures++;
         $display("FAIL reset_dut1: ncs,sclk,busy=%b required 100", {ncs1, sclk1, busy1});
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ncs, busy, done} !== 3'b100) begin
         failures++;
         $display("FAIL idle_after_reset: ncs,busy,done=%b required 100", {ncs, busy, done});
      end
   endtask

   task automatic test_write();
      logic [6:0] a_tab[3] = '{7'h00, 7'h55, 7'h7F};
      logic [7:0] d_tab[3] = '{8'hF0, 8'h3C, 8'h01};
      int dc, dn, nl, rs, ba;
      logic [7:0] rd, rp, r0;
      for (int t = 0; t < 3; t++) begin
         r0 = rdata;
         run_frame(1'b1, a_tab[t], d_tab[t], 8'hFF, 0, 0, FRAME_CYC + 10, dc, dn, nl, rs, rd, rp, ba);
         checks++;
         if (dc !== FRAME_CYC) begin
            failures++;
            $display("FAIL write_done_cycle[%0d]: got %0d required %0d", t, dc, FRAME_CYC);
         end
         checks++;
         if (dn !== 1) begin
            failures++;
            $display("FAIL write_done_count[%0d]: got %0d required 1", t, dn);
         end
         checks++;
         if (nl !== FRAME_CYC - 1) begin
            failures++;
            $display("FAIL write_ncs_low[%0d]: got %0d required %0d", t, nl, FRAME_CYC - 1);
         end
         checks++;
         if (rs !== 16 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL write_rises[%0d]: got %0d left %0d required 16 left 0", t, rs, exp_q.size());
         end
         checks++;
         if (rd !== r0) begin
            failures++;
            $display("FAIL write_rdata_hold[%0d]: got %h required %h", t, rd, r0);
         end
      end
   endtask

   task automatic test_ignore_start();
      int dc, dn, nl, rs, ba;
      logic [7:0] rd, rp;
      run_frame(1'b1, 7'h7F, 8'h81, 8'h00, 1, 0, 300, dc, dn, nl, rs, rd, rp, ba);
      checks++;
      if (dn !== 1 || dc !== FRAME_CYC) begin
         failures++;
         $display("FAIL ignore_done: count %0d cycle %0d required count 1 cycle %0d",
                  dn, dc, FRAME_CYC);
      end
      checks++;
      if (ba !== 0) begin
         failures++;
         $display("FAIL ignore_no_second_frame: busy cycles after done %0d required 0", ba);
      end
      checks++;
      if (rs !== 16) begin
         failures++;
         $display("FAIL ignore_rises: got %0d required 16", rs);
      end
   endtask

   task automatic test_reset_mid();
      int dc, dn, nl, rs, ba;
      logic [7:0] rd, rp;
      run_frame(1'b0, 7'h05, 8'h00, 8'hA5, 0, 50, 60, dc, dn, nl, rs, rd, rp, ba);
      checks++;
      if (dn !== 0) begin
         failures++;
         $display("FAIL abort_no_done: done count %0d required 0", dn);
      end
      repeat (5) @(negedge clk);
      checks++;
      if ({done, busy, rdata} !== {2'b00, 8'h00}) begin
         failures++;
         $display("FAIL abort_quiet: done=%b busy=%b rdata=%h required 0 0 00", done, busy, rdata);
      end
      run_frame(1'b1, 7'h12, 8'hC3, 8'h00, 0, 0, FRAME_CYC + 5, dc, dn, nl, rs, rd, rp, ba);
      checks++;
      if (dc !== FRAME_CYC || rs !== 16 || exp_q.size() != 0 || nl !== FRAME_CYC - 1) begin
         failures++;
         $display("FAIL abort_next_frame: done %0d rises %0d left %0d ncs_low %0d required %0d 16 0 %0d",
                  dc, rs, exp_q.size(), nl, FRAME_CYC, FRAME_CYC - 1);
      end
   endtask

   task automatic test_read();
      int dc, dn, nl, rs, ba;
      logic [7:0] rd, rp, exp_rd;
      exp_rd = READ_EN ? 8'hA5 : 8'h00;
      // wdata is non-zero but a read frame must send a zero data byte.
      run_frame(1'b0, 7'h05, 8'h3C, 8'hA5, 0, 0, FRAME_CYC + 5, dc, dn, nl, rs, rd, rp, ba);
      checks++;
      if (dc !== FRAME_CYC || rs !== 16 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL read_frame: done %0d rises %0d left %0d required %0d 16 0",
                  dc, rs, exp_q.size(), FRAME_CYC);
      end
      checks++;
      if (rp !== 8'h00) begin
         failures++;
         $display("FAIL read_rdata_early: before done got %h required 00", rp);
      end
      checks++;
      if (rd !== exp_rd) begin
         failures++;
         $display("FAIL read_rdata: got %h required %h", rd, exp_rd);
      end
      // A following write must leave the captured byte untouched.
      run_frame(1'b1, 7'h33, 8'h99, 8'h5A, 0, 0, FRAME_CYC + 5, dc, dn, nl, rs, rd, rp, ba);
      checks++;
      if (rd !== exp_rd || rdata !== exp_rd) begin
         failures++;
         $display("FAIL read_rdata_hold: at done %h now %h required %h", rd, rdata, exp_rd);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] frame;
      logic        prev_sclk, exp_bit;
      int          dcyc[3];
      int          nd, ncs_hi;
      frame = {1'b1, 7'h2A, 8'h5B};
      exp_q.delete();
      for (int f = 0; f < 3; f++)
         for (int i = 15; i >= 0; i--) exp_q.push_back(frame[i]);
      nd        = 0;
      ncs_hi    = 0;
      prev_sclk = 1'b0;
      dcyc      = '{-1, -1, -1};
      rw1       = 1'b1;
      addr1     = 7'h2A;
      wdata1    = 8'h5B;
      start1    = 1'b1;
      for (int cyc = 1; cyc <= 110; cyc++) begin
         @(negedge clk);
         if (sclk1 === 1'b1 && prev_sclk === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL b2b_extra_rise: cycle %0d", cyc);
            end else begin
               exp_bit = exp_q.pop_front();
               if (copi1 !== exp_bit) begin
                  failures++;
                  $display("FAIL b2b_copi: cycle %0d got %b required %b", cyc, copi1, exp_bit);
               end
            end
         end
         prev_sclk = sclk1;
         if (ncs1 === 1'b1) ncs_hi++;
         if (done1 === 1'b1) begin
            if (nd < 3) dcyc[nd] = cyc;
            nd++;
         end
      end
      start1 = 1'b0;
      for (int f = 0; f < 3; f++) begin
         checks++;
         if (dcyc[f] !== 35 + 36 * f) begin
            failures++;
            $display("FAIL b2b_done[%0d]: got %0d required %0d", f, dcyc[f], 35 + 36 * f);
         end
      end
      checks++;
      if (nd !== 3 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_count: dones %0d left %0d required 3 0", nd, exp_q.size());
      end
      checks++;
      if (ncs_hi !== 6) begin
         failures++;
         $display("FAIL b2b_ncs_gap: ncs high cycles %0d required 6", ncs_hi);
      end
      repeat (40) @(negedge clk);
      checks++;
      if ({busy1, ncs1, rdata1} !== {2'b01, 8'h00}) begin
         failures++;
         $display("FAIL b2b_end_idle: busy=%b ncs=%b rdata=%h required 0 1 00", busy1, ncs1, rdata1);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_ignore_start();
      test_reset_mid();
      test_read();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
